// File: rtl/alu_issue_arb.sv
// Round-robin issue of two integer ports into one shared ALU, with an operand
// stage (S1), a result stage (S2) and ROB-age based partial flush.
module alu_issue_arb #(
    parameter int DATA_W  = 64,
    parameter int PC_W    = 64,
    parameter int TYPE_W  = 11,
    parameter int ROBID_W = 7
) (
    input  logic               clock,
    input  logic               reset_n,

    input  logic               req0_valid,
    output logic               req0_ready,
    input  logic [DATA_W-1:0]  req0_src1,
    input  logic [DATA_W-1:0]  req0_src2,
    input  logic [DATA_W-1:0]  req0_imm,
    input  logic [PC_W-1:0]    req0_pc,
    input  logic [TYPE_W-1:0]  req0_alu_type,
    input  logic               req0_is_word,
    input  logic               req0_is_unsigned,
    input  logic               req0_is_imm,
    input  logic [ROBID_W-1:0] req0_robid,

    input  logic               req1_valid,
    output logic               req1_ready,
    input  logic [DATA_W-1:0]  req1_src1,
    input  logic [DATA_W-1:0]  req1_src2,
    input  logic [DATA_W-1:0]  req1_imm,
    input  logic [PC_W-1:0]    req1_pc,
    input  logic [TYPE_W-1:0]  req1_alu_type,
    input  logic               req1_is_word,
    input  logic               req1_is_unsigned,
    input  logic               req1_is_imm,
    input  logic [ROBID_W-1:0] req1_robid,

    output logic               alu_valid,
    output logic [DATA_W-1:0]  alu_src1,
    output logic [DATA_W-1:0]  alu_src2,
    output logic [DATA_W-1:0]  alu_imm,
    output logic [PC_W-1:0]    alu_pc,
    output logic [TYPE_W-1:0]  alu_type,
    output logic               alu_is_word,
    output logic               alu_is_unsigned,
    output logic               alu_is_imm,
    input  logic [DATA_W-1:0]  alu_result,

    output logic               wb_valid,
    input  logic               wb_ready,
    output logic [DATA_W-1:0]  wb_result,
    output logic [ROBID_W-1:0] wb_robid,

    input  logic               flush_valid,
    input  logic [ROBID_W-1:0] flush_robid
);

    typedef struct packed {
        logic [DATA_W-1:0]  src1;
        logic [DATA_W-1:0]  src2;
        logic [DATA_W-1:0]  imm;
        logic [PC_W-1:0]    pc;
        logic [TYPE_W-1:0]  alu_type;
        logic               is_word;
        logic               is_unsigned;
        logic               is_imm;
        logic [ROBID_W-1:0] robid;
    } op_t;

    // Younger when the wrap bits differ XOR the index is larger.
    function automatic logic is_younger(input logic [ROBID_W-1:0] e,
                                        input logic [ROBID_W-1:0] f);
        return (e[ROBID_W-1] != f[ROBID_W-1]) ^ (e[ROBID_W-2:0] > f[ROBID_W-2:0]);
    endfunction

    op_t                s1_op;
    logic               s1_valid;
    logic               s2_valid;
    logic [DATA_W-1:0]  s2_result;
    logic [ROBID_W-1:0] s2_robid;
    logic               rr;

    op_t  req0_op, req1_op;
    logic s2_free, s1_adv, s1_free, s1_kill, s2_kill;
    logic sel, grant_ok, hs0, hs1;

    assign req0_op = '{req0_src1, req0_src2, req0_imm, req0_pc, req0_alu_type,
                       req0_is_word, req0_is_unsigned, req0_is_imm, req0_robid};
    assign req1_op = '{req1_src1, req1_src2, req1_imm, req1_pc, req1_alu_type,
                       req1_is_word, req1_is_unsigned, req1_is_imm, req1_robid};

    always_comb begin
        s2_free  = !s2_valid || wb_ready;
        s1_adv   = s1_valid && s2_free;
        s1_free  = !s1_valid || s1_adv;
        s1_kill  = flush_valid && is_younger(s1_op.robid, flush_robid);
        s2_kill  = flush_valid && is_younger(s2_robid, flush_robid);
        // A lone requester wins outright; otherwise (both or neither) rr picks.
        sel      = (req0_valid ^ req1_valid) ? req1_valid : rr;
        grant_ok = reset_n && !flush_valid && s1_free;
        req0_ready = grant_ok && !sel;
        req1_ready = grant_ok && sel;
        hs0 = req0_valid && req0_ready;
        hs1 = req1_valid && req1_ready;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            s1_valid  <= 1'b0;
            s1_op     <= '0;
            s2_valid  <= 1'b0;
            s2_result <= '0;
            s2_robid  <= '0;
            rr        <= 1'b0;
        end else begin
            if (hs0 || hs1) begin
                s1_valid <= 1'b1;
                s1_op    <= hs1 ? req1_op : req0_op;
                rr       <= hs0;
            end else if (s1_adv || s1_kill) begin
                s1_valid <= 1'b0;
            end

            // A killed S1 entry leaves S1 but never lands in S2.
            if (s1_adv && !s1_kill) begin
                s2_valid  <= 1'b1;
                s2_result <= alu_result;
                s2_robid  <= s1_op.robid;
            end else if (s2_free || s2_kill) begin
                s2_valid <= 1'b0;
            end
        end
    end

    assign alu_valid       = s1_valid;
    assign alu_src1        = s1_op.src1;
    assign alu_src2        = s1_op.src2;
    assign alu_imm         = s1_op.imm;
    assign alu_pc          = s1_op.pc;
    assign alu_type        = s1_op.alu_type;
    assign alu_is_word     = s1_op.is_word;
    assign alu_is_unsigned = s1_op.is_unsigned;
    assign alu_is_imm      = s1_op.is_imm;

    assign wb_valid  = s2_valid;
    assign wb_result = s2_result;
    assign wb_robid  = s2_robid;

endmodule

// File: doc/alu_issue_arb.md
Name: alu_issue_arb

Overview:
- Shares one combinational ALU between two integer issue ports (req0, req1).
- Round-robin arbitration selects one op per cycle into an operand register (S1) that drives the ALU inputs.
- The ALU result is captured with its ROB id into a result register (S2), then handed to writeback with a valid/ready handshake.
- Supports partial flush by ROB age. Sits between the int issue queues and the writeback/bypass network.

Parameters:
- DATA_W, 64, operand/result/imm width
- PC_W, 64, pc width
- TYPE_W, 11, one-hot alu_type width
- ROBID_W, 7, ROB id width; MSB is the wrap bit, the remaining bits are the index

Ports:
- clock  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- reqN_valid  in  1  (N=0,1) op offered
- reqN_ready  out  1  op accepted this cycle when valid&ready
- reqN_src1, reqN_src2, reqN_imm  in  DATA_W  operands
- reqN_pc  in  PC_W  instruction pc
- reqN_alu_type  in  TYPE_W  one-hot op select
- reqN_is_word, reqN_is_unsigned, reqN_is_imm  in  1  op modifiers
- reqN_robid  in  ROBID_W  ROB id
- alu_valid  out  1  S1 occupied
- alu_src1, alu_src2, alu_imm  out  DATA_W  from S1
- alu_pc  out  PC_W  from S1
- alu_type  out  TYPE_W  from S1
- alu_is_word, alu_is_unsigned, alu_is_imm  out  1  from S1
- alu_result  in  DATA_W  combinational ALU result for S1 contents
- wb_valid  out  1  S2 holds a result
- wb_ready  in  1  writeback accepts
- wb_result  out  DATA_W  S2 result
- wb_robid  out  ROBID_W  S2 ROB id
- flush_valid  in  1  redirect
- flush_robid  in  ROBID_W  oldest surviving ROB id

Behaviour:
- Reset (async, reset_n=0):
  - S1 and S2 valid=0; data fields are 0; round-robin pointer rr=0.
  - alu_valid=0, wb_valid=0, reqN_ready=0, so all alu_* and wb_* outputs read 0.
  - Reset mid-operation drops all in-flight ops silently.
- Pipeline advance:
  - s2_free = !S2.valid | wb_ready.
  - s1_adv = S1.valid & s2_free: S1 moves to S2 with wb_result=alu_result.
  - s1_free = !S1.valid | s1_adv.
- Arbitration (combinational on the current cycle):
  - If flush_valid: both ready=0.
  - Else if !s1_free: both ready=0.
  - Else if only one valid: that port gets ready=1.
  - Else if both valid: port rr gets ready=1, the other 0.
  - Ready is also asserted with no valid if selected; ready0=1 when idle and rr=0.
  - On a handshake by port k, rr becomes !k.
  - rr does not change without a handshake.
  - At most one handshake per cycle.
- Latency:
  - Handshake in cycle T gives alu_valid=1 in T+1.
  - With wb_ready=1 throughout, wb_valid=1 in T+2.
  - Full throughput is 1 op/cycle.
- Back-pressure:
  - wb_ready=0 with S2 full: S2 holds and S1 holds once full. Inputs stall.
  - wb_result and wb_robid are stable while wb_valid&!wb_ready.
- Flush:
  - An entry is younger than flush_robid when (e.wrap!=f.wrap) XOR (e.idx > f.idx).
  - In a flush cycle, S1 and S2 entries younger than flush_robid are invalidated at the next edge.
  - An entry equal to or older than flush_robid is kept and advances normally.
  - No new op is accepted in a flush cycle.
  - A killed S1 entry is not moved to S2.
  - A flushed S2 may still be handshaken in the same cycle; wb_valid in that cycle is unaffected, and the kill applies from the next edge.
- Simultaneous events:
  - S2 drain, S1 advance and a new S1 fill all occur in the same cycle when allowed.
- Constraints:
  - alu_type out of S1 is forwarded verbatim; this block never decodes it.
  - There is no combinational path from wb_ready to alu_*.
  - A combinational path from wb_ready to reqN_ready exists and is permitted.

Test Plan:
- Single op: req0 valid, ADD, src1=5, src2=7, robid=3 at T; ALU model returns 12 → alu_valid at T+1; wb_valid=1, wb_result=12, wb_robid=3 at T+2.
- Contention: both ports valid continuously with robids 0..7 (req0 even, req1 odd), wb_ready=1 → grants alternate 0,1,0,1; one result per cycle in order 0,1,2,…; rr=0 after reset grants req0 first.
- Back-pressure: stream 3 ops, hold wb_ready=0 for 5 cycles → S2 holds op A stable, S1 holds B, reqN_ready=0; release → A,B,C drain on consecutive cycles, no loss or duplication.
- Flush: S1 robid=0x05, S2 robid=0x03, flush_robid=0x04 → S1 killed (never appears on wb), S2 kept; repeat with wrap: S2 robid=0x41, flush_robid=0x3F → 0x41 killed.
- Flush blocks issue: req0 valid during flush_valid=1 → req0_ready=0; accepted next cycle.
- Async reset mid-stream: deassert reset_n between edges with S1/S2 full → alu_valid, wb_valid, reqN_ready go 0 immediately; after release, the first grant goes to req0.
